// File: rtl/icache_assoc.sv
// Set-associative instruction cache: same-cycle hits, single-line refill from the MMU,
// per-set round-robin replacement and whole-cache invalidation.
module icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  input  logic        pc_changed,
  input  logic        inv_req,
  output logic [31:0] inst_data,
  output logic        inst_ok,
  output logic        inv_done,
  output logic [31:0] inst_addr_mmu,
  output logic        inst_read_req,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_read_data,
  input  logic        mmu_valid,
  input  logic        mmu_last
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WB-1:0] RR_MAX = WB'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} state_e;

  state_e          state_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WB-1:0]   rr_q    [SETS];
  logic [TB-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
  logic [31:0]     buf_q   [LINE_WORDS];
  logic [OB-1:0]   cnt_q;
  logic [29:0]     miss_q;
  logic [WB-1:0]   victim_q;
  logic            inv_pend_q;

  logic [OB-1:0] cur_off, miss_off;
  logic [IB-1:0] cur_idx, miss_idx;
  logic [TB-1:0] cur_tag, miss_tag;

  assign cur_off  = inst_addr[OB+1:2];
  assign cur_idx  = inst_addr[OB+IB+1:OB+2];
  assign cur_tag  = inst_addr[31:OB+IB+2];
  assign miss_off = miss_q[OB-1:0];
  assign miss_idx = miss_q[OB+IB-1:OB];
  assign miss_tag = miss_q[29:OB+IB];

  logic          hit;
  logic [WB-1:0] hit_way, victim;
  logic [31:0]   hit_word, fill_word;
  logic [31:0]   line_w [LINE_WORDS];

  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_q[cur_idx];
    // Walk downwards so the lowest matching / lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[cur_idx][w] && (tag_q[w][cur_idx] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[cur_idx][w]) victim = WB'(w);
    end
  end

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++)
      line_w[i] = (OB'(i) == cnt_q) ? inst_read_data : buf_q[i];
  end

  assign hit_word  = data_q[hit_way][cur_idx][cur_off];
  assign fill_word = line_w[miss_off];

  logic do_inv, lookup, receiving, last_beat, fill_ok;

  assign do_inv    = (state_q == IDLE) && (inv_req || inv_pend_q);
  assign lookup    = (state_q == IDLE) && inst_en && !do_inv;
  assign receiving = (state_q == FILL) || (state_q == DRAIN);
  assign last_beat = receiving && mmu_valid && mmu_last;
  assign fill_ok   = (state_q == FILL) && mmu_valid && mmu_last
                     && !pc_changed && !inv_req && !inv_pend_q;

  assign inst_ok       = !rst && ((lookup && hit) || fill_ok);
  assign inv_done      = !rst && do_inv;
  assign inst_read_req = !rst && ((lookup && !hit) || (state_q == REQ));
  assign inst_addr_mmu = !inst_read_req     ? '0 :
                         (state_q == IDLE)  ? {inst_addr[31:OB+2], {(OB+2){1'b0}}} :
                                              {miss_q[29:OB], {(OB+2){1'b0}}};

  always_comb begin
    inst_data = '0;
    if (inst_ok) inst_data = (state_q == IDLE) ? hit_word : fill_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      miss_q     <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (do_inv) begin
            inv_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              rr_q[s]    <= '0;
            end
          end else if (lookup && !hit) begin
            miss_q   <= inst_addr[31:2];
            victim_q <= victim;
            cnt_q    <= '0;
            state_q  <= inst_addr_ok ? FILL : REQ;
          end
        end
        REQ: begin
          if (inst_addr_ok)    state_q <= pc_changed ? DRAIN : FILL;
          else if (pc_changed) state_q <= IDLE;
        end
        FILL, DRAIN: begin
          if (mmu_valid) cnt_q <= cnt_q + 1'b1;
          if (last_beat) begin
            valid_q[miss_idx][victim_q] <= 1'b1;
            rr_q[miss_idx] <= (rr_q[miss_idx] == RR_MAX) ? '0 : rr_q[miss_idx] + 1'b1;
            state_q <= IDLE;
          end else if ((state_q == FILL) && pc_changed) begin
            state_q <= DRAIN;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (inv_req && (state_q != IDLE)) inv_pend_q <= 1'b1;
    end
  end

  // NOTE: tag/data/buffer storage has no reset; the valid bits alone say whether contents mean anything.
  always_ff @(posedge clk) begin
    if (!rst && receiving && mmu_valid) buf_q[cnt_q] <= inst_read_data;
    if (!rst && last_beat) begin
      tag_q[victim_q][miss_idx] <= miss_tag;
      for (int i = 0; i < LINE_WORDS; i++)
        data_q[victim_q][miss_idx][i] <= line_w[i];
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^inst_addr[1:0];
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (default parameters): refill, hit, eviction,
// redirect, delayed handshake, invalidation and mid-refill reset.
module tb_icache_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0, pc_changed = 1'b0, inv_req = 1'b0;
  logic [31:0] inst_addr = '0, inst_read_data = '0;
  logic        inst_addr_ok = 1'b0, mmu_valid = 1'b0, mmu_last = 1'b0;
  logic [31:0] inst_data, inst_addr_mmu;
  logic        inst_ok, inv_done, inst_read_req;

  int n_checks = 0;
  int n_fail   = 0;

  icache_assoc dut (
    .clk(clk), .rst(rst), .inst_en(inst_en), .inst_addr(inst_addr),
    .pc_changed(pc_changed), .inv_req(inv_req), .inst_data(inst_data),
    .inst_ok(inst_ok), .inv_done(inv_done), .inst_addr_mmu(inst_addr_mmu),
    .inst_read_req(inst_read_req), .inst_addr_ok(inst_addr_ok),
    .inst_read_data(inst_read_data), .mmu_valid(mmu_valid), .mmu_last(mmu_last)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // One cycle: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic en, input logic [31:0] addr,
                       input logic pc, input logic inv, input logic aok,
                       input logic mv, input logic ml, input logic [31:0] rd);
    @(negedge clk);
    rst = r; inst_en = en; inst_addr = addr; pc_changed = pc; inv_req = inv;
    inst_addr_ok = aok; mmu_valid = mv; mmu_last = ml; inst_read_data = rd;
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic aok);
    drive(1'b0, 1'b1, addr, 1'b0, 1'b0, aok, 1'b0, 1'b0, 32'h0);
  endtask

  // Redirect while waiting in REQ (no accept) so the bench returns to IDLE.
  task automatic drop(input logic [31:0] addr);
    drive(1'b0, 1'b1, addr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Feeds 16 refill words base+0 .. base+15 and reports what the DUT showed.
  task automatic feed_line(input logic [31:0] addr, input logic [31:0] base,
                           input int pc_at, input int inv_at,
                           output logic ok_last, output logic [31:0] data_last,
                           output int early_ok, output int req_seen, output int done_seen);
    early_ok = 0; req_seen = 0; done_seen = 0; ok_last = 1'b0; data_last = '0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, addr, (i == pc_at), (i == inv_at), 1'b0, 1'b1, (i == 15), base + i);
      if (i < 15 && (inst_ok !== 1'b0 || inst_data !== 32'h0)) early_ok++;
      if (inst_read_req !== 1'b0) req_seen++;
      if (inv_done !== 1'b0) done_seen++;
      if (i == 15) begin
        ok_last   = inst_ok;
        data_last = inst_data;
      end
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 32'h0000_1044, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
      n_checks++;
      if ({inst_ok, inv_done, inst_read_req} !== 3'b000 || inst_data !== 32'h0 || inst_addr_mmu !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: ok/done/req=%b data=%h mmu=%h, required 000/0/0",
                 {inst_ok, inv_done, inst_read_req}, inst_data, inst_addr_mmu);
      end
    end
  endtask

  task automatic test_cold_fill;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    fetch(32'h0000_1044, 1'b1);
    n_checks++;
    if (inst_read_req !== 1'b1 || inst_addr_mmu !== 32'h0000_1040 || inst_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_req: req=%b mmu=%h ok=%b, required 1 00001040 0", inst_read_req, inst_addr_mmu, inst_ok);
    end
    feed_line(32'h0000_1044, 32'hA0, -1, -1, ok_l, d_l, early, reqs, dones);
    n_checks++;
    if (early !== 0 || reqs !== 0) begin
      n_fail++;
      $display("FAIL cold_during_fill: early_ok=%0d req_cycles=%0d, required 0 0", early, reqs);
    end
    n_checks++;
    if (ok_l !== 1'b1 || d_l !== 32'hA1) begin
      n_fail++;
      $display("FAIL cold_last: ok=%b data=%h, required 1 000000a1", ok_l, d_l);
    end
    fetch(32'h0000_1048, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'hA2 || inst_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_refetch_hit: ok=%b data=%h req=%b, required 1 000000a2 0", inst_ok, inst_data, inst_read_req);
    end
    drive(1'b0, 1'b0, 32'h0000_1048, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_ok !== 1'b0 || inst_data !== 32'h0 || inst_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low: ok=%b data=%h req=%b, required 0 0 0", inst_ok, inst_data, inst_read_req);
    end
  endtask

  task automatic test_evict;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    for (int t = 1; t <= 3; t++) begin
      fetch(32'(t) << 12, 1'b1);
      feed_line(32'(t) << 12, 32'(t) << 8, -1, -1, ok_l, d_l, early, reqs, dones);
      n_checks++;
      if (ok_l !== 1'b1 || d_l !== (32'(t) << 8)) begin
        n_fail++;
        $display("FAIL evict_fill%0d: ok=%b data=%h, required 1 %h", t, ok_l, d_l, 32'(t) << 8);
      end
    end
    fetch(32'h0000_2000, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'h200) begin
      n_fail++;
      $display("FAIL evict_hit_2000: ok=%b data=%h, required 1 00000200", inst_ok, inst_data);
    end
    fetch(32'h0000_3000, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'h300) begin
      n_fail++;
      $display("FAIL evict_hit_3000: ok=%b data=%h, required 1 00000300", inst_ok, inst_data);
    end
    fetch(32'h0000_1000, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b0 || inst_read_req !== 1'b1 || inst_addr_mmu !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL evict_miss_1000: ok=%b req=%b mmu=%h, required 0 1 00001000", inst_ok, inst_read_req, inst_addr_mmu);
    end
    drop(32'h0000_1000);
  endtask

  task automatic test_redirect;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    fetch(32'h0000_4088, 1'b1);
    feed_line(32'h0000_4088, 32'hB00, 4, -1, ok_l, d_l, early, reqs, dones);
    n_checks++;
    if (early !== 0 || ok_l !== 1'b0 || d_l !== 32'h0) begin
      n_fail++;
      $display("FAIL redirect_no_ok: early=%0d ok_last=%b data_last=%h, required 0 0 0", early, ok_l, d_l);
    end
    fetch(32'h0000_4088, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'hB02) begin
      n_fail++;
      $display("FAIL redirect_line_hit: ok=%b data=%h, required 1 00000b02", inst_ok, inst_data);
    end
  endtask

  task automatic test_req_wait;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    for (int c = 0; c < 4; c++) begin
      fetch(32'h0000_50C0, (c == 3));
      n_checks++;
      if (inst_read_req !== 1'b1 || inst_addr_mmu !== 32'h0000_50C0 || inst_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL req_wait_c%0d: req=%b mmu=%h ok=%b, required 1 000050c0 0", c, inst_read_req, inst_addr_mmu, inst_ok);
      end
    end
    feed_line(32'h0000_50C0, 32'hC00, -1, -1, ok_l, d_l, early, reqs, dones);
    n_checks++;
    if (reqs !== 0 || ok_l !== 1'b1 || d_l !== 32'hC00) begin
      n_fail++;
      $display("FAIL req_wait_fill: req_cycles=%0d ok=%b data=%h, required 0 1 00000c00", reqs, ok_l, d_l);
    end
    fetch(32'h0000_6100, 1'b0);
    drop(32'h0000_6100);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_read_req !== 1'b0 || inst_addr_mmu !== 32'h0) begin
      n_fail++;
      $display("FAIL req_dropped: req=%b mmu=%h, required 0 0", inst_read_req, inst_addr_mmu);
    end
    fetch(32'h0000_50C4, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'hC01) begin
      n_fail++;
      $display("FAIL req_dropped_idle_hit: ok=%b data=%h, required 1 00000c01", inst_ok, inst_data);
    end
  endtask

  task automatic test_inv_idle;
    drive(1'b0, 1'b1, 32'h0000_1048, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_ok !== 1'b0 || inv_done !== 1'b1 || inst_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_idle_pulse: ok=%b done=%b req=%b, required 0 1 0", inst_ok, inv_done, inst_read_req);
    end
    fetch(32'h0000_1048, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b0 || inst_read_req !== 1'b1 || inv_done !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_idle_miss: ok=%b req=%b done=%b, required 0 1 0", inst_ok, inst_read_req, inv_done);
    end
    drop(32'h0000_1048);
  endtask

  task automatic test_inv_fill;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    fetch(32'h0000_7140, 1'b1);
    feed_line(32'h0000_7140, 32'hD00, -1, 3, ok_l, d_l, early, reqs, dones);
    n_checks++;
    if (ok_l !== 1'b0 || early !== 0 || dones !== 0) begin
      n_fail++;
      $display("FAIL inv_fill_complete: ok_last=%b early=%0d done_cycles=%0d, required 0 0 0", ok_l, early, dones);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inv_done !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_fill_done: done=%b, required 1", inv_done);
    end
    fetch(32'h0000_7140, 1'b0);
    n_checks++;
    if (inv_done !== 1'b0 || inst_ok !== 1'b0 || inst_read_req !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_fill_miss: done=%b ok=%b req=%b, required 0 0 1", inv_done, inst_ok, inst_read_req);
    end
    drop(32'h0000_7140);
  endtask

  task automatic test_rst_mid;
    logic ok_l; logic [31:0] d_l; int early, reqs, dones;
    fetch(32'h0000_1044, 1'b1);
    feed_line(32'h0000_1044, 32'hA0, -1, -1, ok_l, d_l, early, reqs, dones);
    fetch(32'h0000_1048, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b1 || inst_data !== 32'hA2) begin
      n_fail++;
      $display("FAIL rst_mid_prehit: ok=%b data=%h, required 1 000000a2", inst_ok, inst_data);
    end
    fetch(32'h0000_8180, 1'b1);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 32'h0000_8180, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE00 + i);
    drive(1'b1, 1'b1, 32'h0000_8180, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE08);
    n_checks++;
    if ({inst_ok, inv_done, inst_read_req} !== 3'b000 || inst_data !== 32'h0 || inst_addr_mmu !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_cycle: ok/done/req=%b data=%h mmu=%h, required 000/0/0",
               {inst_ok, inv_done, inst_read_req}, inst_data, inst_addr_mmu);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
    n_checks++;
    if ({inst_ok, inv_done, inst_read_req} !== 3'b000 || inst_data !== 32'h0 || inst_addr_mmu !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_after: ok/done/req=%b data=%h mmu=%h, required 000/0/0",
               {inst_ok, inv_done, inst_read_req}, inst_data, inst_addr_mmu);
    end
    fetch(32'h0000_1048, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b0 || inst_read_req !== 1'b1 || inst_addr_mmu !== 32'h0000_1040) begin
      n_fail++;
      $display("FAIL rst_mid_old_miss: ok=%b req=%b mmu=%h, required 0 1 00001040", inst_ok, inst_read_req, inst_addr_mmu);
    end
    drop(32'h0000_1048);
    fetch(32'h0000_8180, 1'b0);
    n_checks++;
    if (inst_ok !== 1'b0 || inst_read_req !== 1'b1 || inst_addr_mmu !== 32'h0000_8180) begin
      n_fail++;
      $display("FAIL rst_mid_abandoned_miss: ok=%b req=%b mmu=%h, required 0 1 00008180", inst_ok, inst_read_req, inst_addr_mmu);
    end
    drop(32'h0000_8180);
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_evict();
    test_redirect();
    test_req_wait();
    test_inv_idle();
    test_inv_fill();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameter SETS, default 64, sets per way; power of two, 2..256.
REQ-003 Parameter LINE_WORDS, default 16, 32-bit words per line; power of two, 4..16.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 inst_en  input  1  fetch request valid; CPU holds inst_addr stable until inst_ok or pc_changed.
REQ-007 inst_addr  input  32  physical fetch address; bits [1:0] ignored.
REQ-008 pc_changed  input  1  redirect; any outstanding fetch result is no longer wanted.
REQ-009 inv_req  input  1  single-cycle pulse requesting invalidation of the whole cache.
REQ-010 inst_data  output  32  fetched word; 0 whenever inst_ok=0.
REQ-011 inst_ok  output  1  inst_data valid this cycle.
REQ-012 inv_done  output  1  one-cycle pulse in the cycle all valid bits clear.
REQ-013 inst_addr_mmu  output  32  line-aligned refill address; 0 when inst_read_req=0.
REQ-014 inst_read_req  output  1  refill request, held until inst_addr_ok.
REQ-015 inst_addr_ok  input  1  refill request accepted this cycle.
REQ-016 inst_read_data  input  32  refill word.
REQ-017 mmu_valid  input  1  inst_read_data valid; words arrive in order, offset 0 first.
REQ-018 mmu_last  input  1  qualifies final refill word (with mmu_valid).

Function
REQ-019 Address split: offset = addr[OB+1:2], OB=log2(LINE_WORDS); index = next log2(SETS) bits; tag = remaining upper bits.
REQ-020 Per line store: valid bit, tag, LINE_WORDS data words; asynchronous read, synchronous write.
REQ-021 States: IDLE, REQ (handshake), FILL (receiving), DRAIN (receiving, result discarded).
REQ-022 IDLE hit (inst_en, valid and tag match in any way): inst_ok=1 same cycle, inst_data=addressed word, state stays IDLE.
REQ-023 Multiple-way tag match shall not occur; implementation may select lowest way.
REQ-024 IDLE miss: inst_read_req=1, inst_addr_mmu={inst_addr[31:OB+2], zeros}; inst_addr_ok same cycle -> FILL, else -> REQ.
REQ-025 REQ: hold request from latched miss address; inst_addr_ok -> FILL; pc_changed -> drop request, -> IDLE.
REQ-026 Victim fixed at miss: lowest invalid way in set, else per-set round-robin pointer; pointer advances by one (mod WAYS) on each completed fill into that set.
REQ-027 FILL: each mmu_valid writes word to buffer[counter], counter +1; counter wraps mod LINE_WORDS.
REQ-028 mmu_valid & mmu_last in FILL: line, tag and valid written to victim next edge; inst_ok=1 same cycle with requested word, bypassed from inst_read_data when it is the last word; -> IDLE.
REQ-029 pc_changed in FILL without mmu_last -> DRAIN; refill continues to completion.
REQ-030 DRAIN: words captured as FILL; on mmu_last line written, inst_ok stays 0, -> IDLE; new address re-evaluated in IDLE.
REQ-031 pc_changed and mmu_last in same FILL cycle: line written, inst_ok=0, -> IDLE.
REQ-032 mmu_valid outside FILL/DRAIN ignored.
REQ-033 inv_req in IDLE: all valid bits and round-robin pointers cleared next edge; inv_done pulses in that cycle; inst_ok forced 0 in the inv_req cycle.
REQ-034 inv_req in REQ/FILL/DRAIN: latched; refill completes and line is written, then invalidation executes on first IDLE cycle (new line also invalidated); completion-cycle inst_ok forced 0.
REQ-035 inst_en=0 in IDLE: no lookup result, inst_ok=0, no refill.

Reset
REQ-036 rst: state IDLE, all valid bits 0, round-robin pointers 0, counter 0, pending invalidate 0.
REQ-037 Outputs during/after reset: inst_ok=0, inst_data=0, inst_read_req=0, inst_addr_mmu=0, inv_done=0.
REQ-038 rst mid-refill abandons line, nothing written; MMU side shall be reset in the same cycle.

Verification
REQ-039 Cold fetch 0x0000_1044, inst_addr_ok immediate, 16 words 0xA0..0xAF -> inst_addr_mmu=0x0000_1040, inst_ok with 0xA1 on mmu_last cycle; refetch 0x0000_1048 -> hit same cycle, 0xA2.
REQ-040 Defaults, fill tags at 0x0000_1000, 0x0000_2000, 0x0000_3000 (index 0) -> third evicts way 0; 0x0000_1000 misses, 0x0000_2000 hits.
REQ-041 pc_changed at 5th refill word -> refill completes, no inst_ok; line at old address then hits.
REQ-042 inst_addr_ok held low 3 cycles -> inst_read_req high 4 cycles, address stable; pc_changed in cycle 2 -> request dropped, IDLE.
REQ-043 inv_req during FILL -> line written, inv_done one cycle after return to IDLE, next fetch to same line misses.
REQ-044 rst asserted at refill word 8 -> all outputs 0 next cycle; prior hit address now misses.
